// File: rtl/priority_encoder_rr_if.sv
// ---------------------------------------------------------------------------
// priority_encoder_rr_if
// Purpose : Bundles the request, control and grant signals of
//           priority_encoder_rr. The clock and reset are not part of the
//           bundle; they stay plain module ports.
// Signals :
//   i_enable    - gates request capture and new selections
//   i_mode      - 0 = fixed priority (highest index wins), 1 = round-robin
//   i_in        - N request lines, sampled every clock edge
//   i_out_ready - consumer accepts o_out_idx this cycle
//   o_out_valid - o_out_idx holds a granted request
//   o_out_idx   - granted request index
//   o_pending   - latched, not-yet-granted requests
// Modports:
//   slave  - the encoder (consumes requests/control, drives the grant)
//   master - the environment (drives requests/control, observes the grant)
// ---------------------------------------------------------------------------
interface priority_encoder_rr_if #(
  parameter int N     = 8,
  parameter int IDX_W = 3
);
  logic             i_enable;
  logic             i_mode;
  logic [N-1:0]     i_in;
  logic             i_out_ready;
  logic             o_out_valid;
  logic [IDX_W-1:0] o_out_idx;
  logic [N-1:0]     o_pending;

  modport slave (
    input  i_enable,
    input  i_mode,
    input  i_in,
    input  i_out_ready,
    output o_out_valid,
    output o_out_idx,
    output o_pending
  );

  modport master (
    output i_enable,
    output i_mode,
    output i_in,
    output i_out_ready,
    input  o_out_valid,
    input  o_out_idx,
    input  o_pending
  );
endinterface

// File: rtl/priority_encoder_rr.sv
// ---------------------------------------------------------------------------
// priority_encoder_rr
// Purpose : Registered, parametrised priority encoder. Request lines are
//           captured into sticky pending bits; one granted index at a time
//           is presented on a valid/ready output, chosen either by fixed
//           priority (highest index) or by round-robin from a rotating
//           pointer.
// Ports   :
//   i_clk - rising-edge clock
//   i_rst - asynchronous, active-high reset
//   bus   - priority_encoder_rr_if.slave (enable, mode, requests,
//           out_ready in; out_valid, out_idx, pending out)
//
// State | meaning
// ------+--------------------------------------------------------------
// IDLE  | no grant held, out_valid=0; waits for enable and pending!=0
// HOLD  | grant held on out_idx, out_valid=1; stable until out_ready
// ---------------------------------------------------------------------------
module priority_encoder_rr #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  priority_encoder_rr_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [IDX_W:0]   N_EXT = (IDX_W+1)'(N);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(N - 1);

  state_t           r_state;
  logic [N-1:0]     r_pending;
  logic             r_valid;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_ptr;

  logic [IDX_W-1:0] w_fix_idx;
  logic [IDX_W-1:0] w_rr_idx;
  logic [IDX_W-1:0] w_sel;
  logic [IDX_W-1:0] w_ptr_next;
  logic             w_any;
  logic             w_fire;
  logic             w_load;
  logic [N-1:0]     w_load_mask;
  logic [N-1:0]     w_capture;

  // Fixed priority: later (higher) set bits overwrite earlier ones.
  always_comb begin
    w_fix_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (r_pending[i]) w_fix_idx = IDX_W'(i);
    end
  end

  // Round-robin: walk offsets from farthest to nearest so the set bit
  // closest to r_ptr (ascending, wrapping at N) is the last writer.
  // The wrap is done against N, not 2^IDX_W, so out-of-range indices
  // are never formed for non-power-of-two N.
  always_comb begin : rr_search
    logic [IDX_W:0] j;
    w_rr_idx = '0;
    j        = '0;
    for (int off = N - 1; off >= 0; off--) begin
      j = {1'b0, r_ptr} + (IDX_W+1)'(off);
      if (j >= N_EXT) j = j - N_EXT;
      if (r_pending[j[IDX_W-1:0]]) w_rr_idx = j[IDX_W-1:0];
    end
  end

  assign w_sel      = bus.i_mode ? w_rr_idx : w_fix_idx;
  assign w_ptr_next = (w_sel == LAST) ? '0 : w_sel + 1'b1;
  assign w_any      = |r_pending;
  assign w_fire     = r_valid & bus.i_out_ready;

  // A new index may be loaded from IDLE, or in HOLD on the same edge the
  // current grant transfers (back-to-back, one grant per cycle).
  assign w_load      = bus.i_enable & w_any & (~r_valid | w_fire);
  assign w_load_mask = w_load ? (N'(1) << w_sel) : '0;
  assign w_capture   = bus.i_enable ? bus.i_in : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_valid   <= 1'b0;
      r_idx     <= '0;
      r_ptr     <= '0;
    end else begin
      // A request on the loaded bit in the same cycle is re-captured,
      // so a level held high regenerates every cycle.
      r_pending <= (r_pending & ~w_load_mask) | w_capture;

      if (w_load && bus.i_mode) r_ptr <= w_ptr_next;

      case (r_state)
        IDLE: begin
          if (w_load) begin
            r_idx   <= w_sel;
            r_valid <= 1'b1;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (w_fire) begin
            if (w_load) begin
              r_idx <= w_sel;
            end else begin
              // out_idx deliberately keeps its last value in IDLE.
              r_valid <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_out_valid = r_valid;
  assign bus.o_out_idx   = r_idx;
  assign bus.o_pending   = r_pending;

endmodule
